// File: rtl/or1k_pcu_evtgen.sv
// Performance-event generator feeding the performance counter unit.
// Turns raw pipeline, LSU, fetch, cache and MMU status into registered,
// single-cycle event strobes plus a privilege-mode flag aligned to them.
// Every event is computed combinationally, gated by freeze_i, then registered,
// so every strobe has one cycle of latency from the sampled condition.

module or1k_pcu_evtgen #(
    parameter int unsigned BRN_PENALTY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze_i,
    input  logic sys_mode_i,
    input  logic ifetch_req_i,
    input  logic ifetch_ack_i,
    input  logic lsu_valid_i,
    input  logic lsu_we_i,
    input  logic lsu_ack_i,
    input  logic lsu_except_i,
    input  logic icache_refill_i,
    input  logic dcache_refill_i,
    input  logic itlb_reload_i,
    input  logic dtlb_reload_i,
    input  logic ifetch_stall_i,
    input  logic lsu_stall_i,
    input  logic datadep_stall_i,
    input  logic brn_mispredict_i,
    output logic spr_sys_mode_o,
    output logic pcu_event_load_o,
    output logic pcu_event_store_o,
    output logic pcu_event_ifetch_o,
    output logic pcu_event_dcache_miss_o,
    output logic pcu_event_icache_miss_o,
    output logic pcu_event_ifetch_stall_o,
    output logic pcu_event_lsu_stall_o,
    output logic pcu_event_brn_stall_o,
    output logic pcu_event_dtlb_miss_o,
    output logic pcu_event_itlb_miss_o,
    output logic pcu_event_datadep_stall_o
);

    // Bit positions inside the packed event vector.
    localparam int unsigned EvLoad     = 0;
    localparam int unsigned EvStore    = 1;
    localparam int unsigned EvIfetch   = 2;
    localparam int unsigned EvDcMiss   = 3;
    localparam int unsigned EvIcMiss   = 4;
    localparam int unsigned EvIfStall  = 5;
    localparam int unsigned EvLsuStall = 6;
    localparam int unsigned EvBrnStall = 7;
    localparam int unsigned EvDtlbMiss = 8;
    localparam int unsigned EvItlbMiss = 9;
    localparam int unsigned EvDdStall  = 10;
    localparam int unsigned NumEv      = 11;

    // Bit positions inside the level-history vector.
    localparam int unsigned LvIcache = 0;
    localparam int unsigned LvDcache = 1;
    localparam int unsigned LvItlb   = 2;
    localparam int unsigned LvDtlb   = 3;

    localparam logic [3:0] PenLoad = 4'(BRN_PENALTY);

    logic             ack_seen_q, ack_seen_d;
    logic [3:0]       lvl_hist_q, lvl_hist_d;
    logic [3:0]       lvl_now;
    logic [3:0]       lvl_rise;
    logic [3:0]       pen_cnt_q, pen_cnt_d;
    logic             sys_mode_q;
    logic             lsu_first_ack;
    logic [NumEv-1:0] evt_raw;
    logic [NumEv-1:0] evt_d, evt_q;

    // First ack of an LSU access; later cycles of a held ack are ignored.
    assign lsu_first_ack = lsu_valid_i & lsu_ack_i & ~ack_seen_q;

    // Track whether the current access has already been counted.
    // Dropping lsu_valid_i ends the access and re-arms the detector.
    always_comb begin
        ack_seen_d = ack_seen_q;
        if (!lsu_valid_i) begin
            ack_seen_d = 1'b0;
        end else if (lsu_ack_i) begin
            ack_seen_d = 1'b1;
        end
    end

    assign lvl_now = {dtlb_reload_i, itlb_reload_i, dcache_refill_i, icache_refill_i};

    // Rising-edge detect of refill/reload levels; history always follows the level,
    // so a level that rises while frozen is already "old" once freeze releases.
    always_comb begin
        lvl_hist_d = lvl_now;
        lvl_rise   = lvl_now & ~lvl_hist_q;
    end

    // Branch penalty window: a mispredict (re)loads, otherwise count down to zero.
    always_comb begin
        pen_cnt_d = pen_cnt_q;
        if (brn_mispredict_i) begin
            pen_cnt_d = PenLoad;
        end else if (pen_cnt_q != 4'd0) begin
            pen_cnt_d = pen_cnt_q - 4'd1;
        end
    end

    // Raw next-cycle event conditions, before debug-freeze gating.
    always_comb begin
        evt_raw             = '0;
        evt_raw[EvLoad]     = lsu_first_ack & ~lsu_we_i & ~lsu_except_i;
        evt_raw[EvStore]    = lsu_first_ack &  lsu_we_i & ~lsu_except_i;
        evt_raw[EvIfetch]   = ifetch_req_i & ifetch_ack_i;
        evt_raw[EvDcMiss]   = lvl_rise[LvDcache];
        evt_raw[EvIcMiss]   = lvl_rise[LvIcache];
        evt_raw[EvIfStall]  = ifetch_stall_i;
        evt_raw[EvLsuStall] = lsu_stall_i;
        evt_raw[EvBrnStall] = (pen_cnt_d != 4'd0);
        evt_raw[EvDtlbMiss] = lvl_rise[LvDtlb];
        evt_raw[EvItlbMiss] = lvl_rise[LvItlb];
        evt_raw[EvDdStall]  = datadep_stall_i;
    end

    // Freeze drops events sampled this cycle; they are never replayed.
    always_comb begin
        evt_d = evt_raw & {NumEv{~freeze_i}};
    end

    // State and output registers; history and penalty counter run even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_seen_q <= 1'b0;
            lvl_hist_q <= '0;
            pen_cnt_q  <= '0;
            sys_mode_q <= 1'b1;
            evt_q      <= '0;
        end else begin
            ack_seen_q <= ack_seen_d;
            lvl_hist_q <= lvl_hist_d;
            pen_cnt_q  <= pen_cnt_d;
            sys_mode_q <= sys_mode_i;
            evt_q      <= evt_d;
        end
    end

    assign spr_sys_mode_o            = sys_mode_q;
    assign pcu_event_load_o          = evt_q[EvLoad];
    assign pcu_event_store_o         = evt_q[EvStore];
    assign pcu_event_ifetch_o        = evt_q[EvIfetch];
    assign pcu_event_dcache_miss_o   = evt_q[EvDcMiss];
    assign pcu_event_icache_miss_o   = evt_q[EvIcMiss];
    assign pcu_event_ifetch_stall_o  = evt_q[EvIfStall];
    assign pcu_event_lsu_stall_o     = evt_q[EvLsuStall];
    assign pcu_event_brn_stall_o     = evt_q[EvBrnStall];
    assign pcu_event_dtlb_miss_o     = evt_q[EvDtlbMiss];
    assign pcu_event_itlb_miss_o     = evt_q[EvItlbMiss];
    assign pcu_event_datadep_stall_o = evt_q[EvDdStall];

endmodule

// File: tb/tb_or1k_pcu_evtgen.sv
// Self-checking bench for or1k_pcu_evtgen: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the event rules.

module tb_or1k_pcu_evtgen;

    localparam int unsigned P = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, freeze_i, sys_mode_i, ifetch_req_i, ifetch_ack_i;
    logic lsu_valid_i, lsu_we_i, lsu_ack_i, lsu_except_i;
    logic icache_refill_i, dcache_refill_i, itlb_reload_i, dtlb_reload_i;
    logic ifetch_stall_i, lsu_stall_i, datadep_stall_i, brn_mispredict_i;
    logic spr_sys_mode_o, ev_load, ev_store, ev_ifetch, ev_dmiss, ev_imiss;
    logic ev_ifstall, ev_lsustall, ev_brn, ev_dtlb, ev_itlb, ev_dd;

    or1k_pcu_evtgen #(.BRN_PENALTY(P)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .freeze_i                  (freeze_i),
        .sys_mode_i                (sys_mode_i),
        .ifetch_req_i              (ifetch_req_i),
        .ifetch_ack_i              (ifetch_ack_i),
        .lsu_valid_i               (lsu_valid_i),
        .lsu_we_i                  (lsu_we_i),
        .lsu_ack_i                 (lsu_ack_i),
        .lsu_except_i              (lsu_except_i),
        .icache_refill_i           (icache_refill_i),
        .dcache_refill_i           (dcache_refill_i),
        .itlb_reload_i             (itlb_reload_i),
        .dtlb_reload_i             (dtlb_reload_i),
        .ifetch_stall_i            (ifetch_stall_i),
        .lsu_stall_i               (lsu_stall_i),
        .datadep_stall_i           (datadep_stall_i),
        .brn_mispredict_i          (brn_mispredict_i),
        .spr_sys_mode_o            (spr_sys_mode_o),
        .pcu_event_load_o          (ev_load),
        .pcu_event_store_o         (ev_store),
        .pcu_event_ifetch_o        (ev_ifetch),
        .pcu_event_dcache_miss_o   (ev_dmiss),
        .pcu_event_icache_miss_o   (ev_imiss),
        .pcu_event_ifetch_stall_o  (ev_ifstall),
        .pcu_event_lsu_stall_o     (ev_lsustall),
        .pcu_event_brn_stall_o     (ev_brn),
        .pcu_event_dtlb_miss_o     (ev_dtlb),
        .pcu_event_itlb_miss_o     (ev_itlb),
        .pcu_event_datadep_stall_o (ev_dd)
    );

    // {sys, load, store, ifetch, dmiss, imiss, ifstall, lsustall, brn, dtlb, itlb, datadep}
    logic [11:0] outs;
    assign outs = {spr_sys_mode_o, ev_load, ev_store, ev_ifetch, ev_dmiss, ev_imiss,
                   ev_ifstall, ev_lsustall, ev_brn, ev_dtlb, ev_itlb, ev_dd};

    int checks = 0;
    int fails  = 0;

    // Reference model state.
    logic [11:0] exp_v;
    logic [3:0]  prev_lv;   // {icache, dcache, itlb, dtlb} seen last cycle
    bit          acked;     // current LSU access already counted
    int          since;     // cycles since last mispredict (1000 = none)

    task automatic clear_inputs();
        freeze_i = 0; sys_mode_i = 0; ifetch_req_i = 0; ifetch_ack_i = 0;
        lsu_valid_i = 0; lsu_we_i = 0; lsu_ack_i = 0; lsu_except_i = 0;
        icache_refill_i = 0; dcache_refill_i = 0; itlb_reload_i = 0; dtlb_reload_i = 0;
        ifetch_stall_i = 0; lsu_stall_i = 0; datadep_stall_i = 0; brn_mispredict_i = 0;
    endtask

    // Evaluate the model on the inputs present at this edge, then advance one clock.
    task automatic tick();
        logic [3:0]  lv, rise;
        logic [10:0] ev;
        bit          first;
        if (rst) begin
            exp_v   = 12'h800;
            prev_lv = 4'b0;
            acked   = 0;
            since   = 1000;
        end else begin
            if (brn_mispredict_i) since = 0;
            else if (since < 1000) since++;
            first = lsu_valid_i && lsu_ack_i && !acked;
            if (!lsu_valid_i) acked = 0;
            else if (lsu_ack_i) acked = 1;
            lv      = {icache_refill_i, dcache_refill_i, itlb_reload_i, dtlb_reload_i};
            rise    = lv & ~prev_lv;
            prev_lv = lv;
            ev[10] = first && !lsu_we_i && !lsu_except_i;
            ev[9]  = first && lsu_we_i && !lsu_except_i;
            ev[8]  = ifetch_req_i && ifetch_ack_i;
            ev[7]  = rise[2];
            ev[6]  = rise[3];
            ev[5]  = ifetch_stall_i;
            ev[4]  = lsu_stall_i;
            ev[3]  = (since < P);
            ev[2]  = rise[0];
            ev[1]  = rise[1];
            ev[0]  = datadep_stall_i;
            if (freeze_i) ev = '0;
            exp_v = {sys_mode_i, ev};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        dcache_refill_i = 1; ifetch_stall_i = 1; brn_mispredict_i = 1; sys_mode_i = 0;
        tick();
        tick();
        checks++;
        if (outs !== 12'h800) begin
            fails++;
            $display("FAIL reset_state got=%03h want=%03h", outs, 12'h800);
        end
        clear_inputs();
        tick();
        rst = 0;
        tick();
        checks++;
        if (outs !== exp_v) begin
            fails++;
            $display("FAIL reset_release got=%03h want=%03h", outs, exp_v);
        end
    endtask

    task automatic test_load_dedup();
        int cnt;
        for (int pass = 0; pass < 2; pass++) begin
            clear_inputs();
            tick();
            cnt = 0;
            for (int i = 0; i < 5; i++) begin
                lsu_valid_i = (i < 3); lsu_ack_i = (i < 3); lsu_except_i = (pass == 1);
                tick();
                cnt += int'(ev_load);
                checks++;
                if (outs !== exp_v) begin
                    fails++;
                    $display("FAIL load_cycle pass=%0d i=%0d got=%03h want=%03h",
                             pass, i, outs, exp_v);
                end
            end
            checks++;
            if (cnt != ((pass == 0) ? 1 : 0)) begin
                fails++;
                $display("FAIL load_pulse_count pass=%0d got=%0d want=%0d",
                         pass, cnt, (pass == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_dcache_miss();
        logic [11:0] pat;
        int cnt;
        pat = 12'b0_1111_00_11111; // bit i = level in cycle i: 5 high, 2 low, 4 high, low
        clear_inputs();
        tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            dcache_refill_i = pat[i];
            tick();
            cnt += int'(ev_dmiss);
            checks++;
            if (ev_dmiss !== ((i == 0) || (i == 7))) begin
                fails++;
                $display("FAIL dcache_miss_timing i=%0d got=%b want=%b",
                         i, ev_dmiss, (i == 0) || (i == 7));
            end
        end
        checks++;
        if (cnt != 2) begin
            fails++;
            $display("FAIL dcache_miss_count got=%0d want=2", cnt);
        end
    endtask

    task automatic test_brn_window();
        int cnt;
        for (int n = 1; n <= 2; n++) begin
            clear_inputs();
            tick(); tick(); tick();
            cnt = 0;
            for (int i = 0; i < 6; i++) begin
                brn_mispredict_i = (i < n);
                tick();
                cnt += int'(ev_brn);
                checks++;
                if (ev_brn !== (i < n + P - 1)) begin
                    fails++;
                    $display("FAIL brn_window n=%0d i=%0d got=%b want=%b",
                             n, i, ev_brn, i < n + P - 1);
                end
            end
            checks++;
            if (cnt != n + P - 1) begin
                fails++;
                $display("FAIL brn_count n=%0d got=%0d want=%0d", n, cnt, n + P - 1);
            end
        end
    endtask

    task automatic test_freeze();
        int cnt;
        clear_inputs();
        tick();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            lsu_stall_i = (i < 7);
            freeze_i    = (i >= 2 && i <= 4);
            tick();
            cnt += int'(ev_lsustall);
        end
        checks++;
        if (cnt != 4) begin
            fails++;
            $display("FAIL freeze_lsu_stall_count got=%0d want=4", cnt);
        end
        clear_inputs();
        tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            itlb_reload_i = 1;
            freeze_i      = (i == 0);
            tick();
            cnt += int'(ev_itlb);
        end
        checks++;
        if (cnt != 0) begin
            fails++;
            $display("FAIL freeze_itlb_count got=%0d want=0", cnt);
        end
    endtask

    task automatic drive_all(input logic we);
        sys_mode_i = 1; ifetch_req_i = 1; ifetch_ack_i = 1;
        lsu_valid_i = 1; lsu_ack_i = 1; lsu_we_i = we;
        icache_refill_i = 1; dcache_refill_i = 1; itlb_reload_i = 1; dtlb_reload_i = 1;
        ifetch_stall_i = 1; lsu_stall_i = 1; datadep_stall_i = 1; brn_mispredict_i = 1;
    endtask

    task automatic test_all_events();
        clear_inputs();
        tick(); tick(); tick();
        drive_all(1'b0);
        tick();
        checks++;
        if (outs !== 12'hDFF) begin
            fails++;
            $display("FAIL all_events_load got=%03h want=%03h", outs, 12'hDFF);
        end
        clear_inputs();
        tick(); tick(); tick();
        drive_all(1'b1);
        tick();
        checks++;
        if (outs !== 12'hBFF) begin
            fails++;
            $display("FAIL all_events_store got=%03h want=%03h", outs, 12'hBFF);
        end
    endtask

    task automatic test_sys_mode();
        clear_inputs();
        sys_mode_i = 1;
        tick();
        sys_mode_i = 0;
        checks++;
        if (spr_sys_mode_o !== 1'b1) begin
            fails++;
            $display("FAIL sys_mode_high got=%b want=1", spr_sys_mode_o);
        end
        tick();
        checks++;
        if (spr_sys_mode_o !== 1'b0) begin
            fails++;
            $display("FAIL sys_mode_low got=%b want=0", spr_sys_mode_o);
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        tick();
        brn_mispredict_i = 1; lsu_valid_i = 1; lsu_ack_i = 1;
        tick();
        brn_mispredict_i = 0; lsu_ack_i = 0;
        tick(); // pending window 1 cycle, access already counted
        rst = 1; lsu_ack_i = 1; dcache_refill_i = 1; lsu_stall_i = 1;
        tick();
        checks++;
        if (outs !== 12'h800) begin
            fails++;
            $display("FAIL reset_mid got=%03h want=%03h", outs, 12'h800);
        end
        rst = 0;
        tick();
        checks++;
        if (outs !== exp_v) begin
            fails++;
            $display("FAIL reset_mid_after got=%03h want=%03h", outs, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom_range(0, 49) == 0);
            freeze_i         = ($urandom_range(0, 4) == 0);
            sys_mode_i       = 1'($urandom);
            ifetch_req_i     = 1'($urandom);
            ifetch_ack_i     = 1'($urandom);
            if ($urandom_range(0, 3) == 0) lsu_valid_i = ~lsu_valid_i;
            lsu_we_i         = 1'($urandom);
            lsu_ack_i        = 1'($urandom);
            lsu_except_i     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) icache_refill_i = ~icache_refill_i;
            if ($urandom_range(0, 3) == 0) dcache_refill_i = ~dcache_refill_i;
            if ($urandom_range(0, 3) == 0) itlb_reload_i   = ~itlb_reload_i;
            if ($urandom_range(0, 3) == 0) dtlb_reload_i   = ~dtlb_reload_i;
            ifetch_stall_i   = 1'($urandom);
            lsu_stall_i      = 1'($urandom);
            datadep_stall_i  = 1'($urandom);
            brn_mispredict_i = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (outs !== exp_v) begin
                fails++;
                $display("FAIL random_cycle i=%0d got=%03h want=%03h", i, outs, exp_v);
            end
        end
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_load_dedup();
        test_dcache_miss();
        test_brn_window();
        test_freeze();
        test_all_events();
        test_sys_mode();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
